pixel_packer: RTL and testbench

Consumer end of the ray-tracer pixel stream: accepts one RGB888 pixel per handshake from the pixel buffer (`out_r/out_g/out_b/out_valid` into `in_stream_ready`). It packs every four pixels into three 32-bit AXI4-Stream words for the VDMA. It tracks raster position to generate `tuser` (start of frame) and `tlast` (end of line), and pulses `frame_done` after the last word of each frame.

---
 rtl/pixel_packer_if.sv | 32 +++
 rtl/pixel_packer.sv | 126 ++++++++++++
 tb/tb_pixel_packer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_packer_if.sv
// Pixel-in / packed-word-out bundle for the pixel packer.
// Valid/ready rule for both streams: a transfer happens on the rising clock
// edge where valid and ready are both high. The source holds its payload
// stable while valid is high and ready is low. The sink's ready never depends
// combinationally on the source's valid.
// slave  : the packer (consumes pixels, produces words)
// master : the environment (pixel source plus word sink)
interface pixel_packer_if;
    logic [7:0]  in_r;
    logic [7:0]  in_g;
    logic [7:0]  in_b;
    logic        in_valid;
    logic        in_stream_ready;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tuser;
    logic        out_stream_tvalid;
    logic        out_stream_tready;

    modport slave (
        input  in_r, in_g, in_b, in_valid, out_stream_tready,
        output in_stream_ready, out_stream_tdata, out_stream_tkeep,
        output out_stream_tlast, out_stream_tuser, out_stream_tvalid
    );

    modport master (
        output in_r, in_g, in_b, in_valid, out_stream_tready,
        input  in_stream_ready, out_stream_tdata, out_stream_tkeep,
        input  out_stream_tlast, out_stream_tuser, out_stream_tvalid
    );
endinterface

// File: rtl/pixel_packer.sv
// Packs four RGB888 pixels into three 32-bit stream words, blue byte first.
// Raster counters mark the first word of a frame (tuser) and the last word
// of each line (tlast); frame_done pulses after the frame's final word leaves.
module pixel_packer #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic              aclk,
    input  logic              aresetn,
    pixel_packer_if.slave     bus,
    output logic              frame_done,
    output logic [1:0]        dbg_phase
);
    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    logic [1:0]    phase;
    logic [1:0]    phase_next;
    logic [23:0]   partial;
    logic [23:0]   partial_next;
    logic [23:0]   p;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          ready;
    logic          accept;
    logic          emit;
    logic [31:0]   word;
    logic          word_last;
    logic          word_user;
    logic          word_eof;
    logic [31:0]   tdata;
    logic          tvalid;
    logic          tlast;
    logic          tuser;
    logic          eof;

    assign p      = {bus.in_r, bus.in_g, bus.in_b};
    // Phase 0 never emits, so it may take a pixel even while a word is stalled.
    assign ready  = (phase == 2'd0) || !tvalid || bus.out_stream_tready;
    assign accept = bus.in_valid && ready;

    assign bus.in_stream_ready   = ready;
    assign bus.out_stream_tdata  = tdata;
    assign bus.out_stream_tkeep  = 4'hF;
    assign bus.out_stream_tlast  = tlast;
    assign bus.out_stream_tuser  = tuser;
    assign bus.out_stream_tvalid = tvalid;
    assign dbg_phase             = phase;

    // Phase state register: position of the next pixel inside its 4-pixel group.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) phase <= 2'd0;
        else          phase <= phase_next;
    end

    // Next phase: advance on every accepted pixel, wrapping 3 -> 0.
    always_comb begin
        phase_next = phase;
        if (accept) phase_next = phase + 2'd1;
    end

    // Phase outputs: word to emit, leftover bytes to keep, and word markers.
    always_comb begin
        emit         = accept && (phase != 2'd0);
        word         = '0;
        partial_next = partial;
        case (phase)
            2'd0: partial_next = p;
            2'd1: begin
                word         = {p[7:0], partial};
                partial_next = {partial[23:16], p[23:8]};
            end
            2'd2: begin
                word         = {p[15:0], partial[15:0]};
                partial_next = {partial[23:8], p[23:16]};
            end
            default: word = {p, partial[7:0]};
        endcase
        word_user = (phase == 2'd1) && (x == XW'(1)) && (y == '0);
        word_last = (phase == 2'd3) && (x == X_LAST);
        word_eof  = word_last && (y == Y_LAST);
    end

    // Holding register and raster position of the pixel being accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            partial <= '0;
            x       <= '0;
            y       <= '0;
        end else if (accept) begin
            partial <= partial_next;
            if (x == X_LAST) begin
                x <= '0;
                if (y == Y_LAST) y <= '0;
                else             y <= y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // Output word register; a new word may replace one leaving in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tdata      <= '0;
            tlast      <= 1'b0;
            tuser      <= 1'b0;
            tvalid     <= 1'b0;
            eof        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= tvalid && bus.out_stream_tready && eof;
            if (emit) begin
                tdata  <= word;
                tlast  <= word_last;
                tuser  <= word_user;
                eof    <= word_eof;
                tvalid <= 1'b1;
            end else if (bus.out_stream_tready) begin
                tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer with an 8x2 raster.
module tb_pixel_packer;
    localparam int X_SIZE = 8;
    localparam int Y_SIZE = 2;
    localparam int WPL    = X_SIZE * 3 / 4;
    localparam int WPF    = WPL * Y_SIZE;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       aresetn;
    logic       frame_done;
    logic [1:0] dbg_phase;

    pixel_packer_if bus();

    pixel_packer #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) dut (
        .aclk(clk),
        .aresetn(aresetn),
        .bus(bus),
        .frame_done(frame_done),
        .dbg_phase(dbg_phase)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- scoreboard ----------------
    // Entries are {tuser, tlast, tdata}.
    logic [33:0] exp_q[$];
    logic [33:0] got_q[$];
    logic [7:0]  byte_q[$];
    int          model_word_idx;
    int          model_phase;
    int          fd_cnt;
    int          fd_words;
    int          fd_lag;
    int          cyc = 0;
    int          last_word_cyc = 0;
    logic        pix_fire = 1'b0;
    logic        word_fire = 1'b0;
    logic [23:0] pix_word;
    logic [33:0] word_val;
    logic [31:0] w;

    always @(negedge clk) begin
        pix_fire  = aresetn && bus.in_valid && bus.in_stream_ready;
        pix_word  = {bus.in_r, bus.in_g, bus.in_b};
        word_fire = aresetn && bus.out_stream_tvalid && bus.out_stream_tready;
        word_val  = {bus.out_stream_tuser, bus.out_stream_tlast, bus.out_stream_tdata};
        if (aresetn && frame_done) begin
            fd_cnt++;
            fd_words = got_q.size();
            fd_lag   = cyc - last_word_cyc;
        end
    end

    // Reference: pixels become a little-endian byte stream cut into 32-bit words.
    always @(posedge clk) begin
        cyc++;
        if (pix_fire) begin
            byte_q.push_back(pix_word[7:0]);
            byte_q.push_back(pix_word[15:8]);
            byte_q.push_back(pix_word[23:16]);
            while (byte_q.size() >= 4) begin
                w = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
                repeat (4) void'(byte_q.pop_front());
                exp_q.push_back({(model_word_idx % WPF) == 0,
                                 (model_word_idx % WPL) == WPL - 1, w});
                model_word_idx++;
            end
            model_phase = (model_phase + 1) % 4;
            pix_fire = 1'b0;
        end
        if (word_fire) begin
            got_q.push_back(word_val);
            last_word_cyc = cyc;
            word_fire = 1'b0;
        end
    end

    task automatic model_clear();
        exp_q.delete();
        got_q.delete();
        byte_q.delete();
        model_word_idx = 0;
        model_phase    = 0;
        fd_cnt         = 0;
        fd_words       = -1;
        fd_lag         = -1;
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [23:0] pix_of(input int i);
        return {8'(8'h10 + i), 8'(8'h80 + i * 3), 8'(8'hC0 + i * 7)};
    endfunction

    task automatic send_pixel(input logic [23:0] p);
        int waited;
        waited = 0;
        {bus.in_r, bus.in_g, bus.in_b} = p;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_stream_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!bus.in_stream_ready) begin
            failures++;
            $display("FAIL send_timeout pixel=%h ready=0 required=1", p);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_words(input int n);
        int b;
        b = 0;
        bus.in_valid = 1'b0;
        while (got_q.size() < n && b < 500) begin
            @(posedge clk); #1;
            b++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        aresetn = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_stream_tready = 1'b1;
        #1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_stream(input string name, input int n);
        checks++;
        if (got_q.size() !== n) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_word%0d got=%h exp=%h", name, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        aresetn = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_r = '0; bus.in_g = '0; bus.in_b = '0;
        bus.out_stream_tready = 1'b0;
        model_clear();
        #2 aresetn = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_stream_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", bus.out_stream_tvalid); end
        checks++; if (bus.out_stream_tdata !== 32'h0) begin failures++; $display("FAIL rst_tdata got=%h exp=0", bus.out_stream_tdata); end
        checks++; if (bus.out_stream_tlast !== 1'b0) begin failures++; $display("FAIL rst_tlast got=%b exp=0", bus.out_stream_tlast); end
        checks++; if (bus.out_stream_tuser !== 1'b0) begin failures++; $display("FAIL rst_tuser got=%b exp=0", bus.out_stream_tuser); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
        checks++; if (bus.in_stream_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.in_stream_ready); end
        checks++; if (dbg_phase !== 2'd0) begin failures++; $display("FAIL rst_phase got=%0d exp=0", dbg_phase); end
        checks++; if (bus.out_stream_tkeep !== 4'hF) begin failures++; $display("FAIL rst_tkeep got=%h exp=F", bus.out_stream_tkeep); end
        aresetn = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.in_stream_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", bus.in_stream_ready); end
    endtask

    task automatic test_basic_pack();
        logic [23:0] px[8] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C,
                               24'h0D0E0F, 24'h101112, 24'h131415, 24'h161718};
        apply_reset();
        for (int i = 0; i < 8; i++) send_pixel(px[i]);
        wait_words(6);
        checks++; if (got_q.size() !== 6) begin failures++; $display("FAIL basic_count got=%0d exp=6", got_q.size()); end
        checks++; if (got_q[0] !== {1'b1, 1'b0, 32'h06010203}) begin failures++; $display("FAIL basic_w0 got=%h exp=%h", got_q[0], {1'b1, 1'b0, 32'h06010203}); end
        checks++; if (got_q[1] !== {1'b0, 1'b0, 32'h08090405}) begin failures++; $display("FAIL basic_w1 got=%h exp=%h", got_q[1], {1'b0, 1'b0, 32'h08090405}); end
        checks++; if (got_q[2] !== {1'b0, 1'b0, 32'h0A0B0C07}) begin failures++; $display("FAIL basic_w2 got=%h exp=%h", got_q[2], {1'b0, 1'b0, 32'h0A0B0C07}); end
        checks++; if (got_q[3] !== {1'b0, 1'b0, 32'h120D0E0F}) begin failures++; $display("FAIL basic_w3 got=%h exp=%h", got_q[3], {1'b0, 1'b0, 32'h120D0E0F}); end
        checks++; if (got_q[4] !== {1'b0, 1'b0, 32'h14151011}) begin failures++; $display("FAIL basic_w4 got=%h exp=%h", got_q[4], {1'b0, 1'b0, 32'h14151011}); end
        checks++; if (got_q[5] !== {1'b0, 1'b1, 32'h16171813}) begin failures++; $display("FAIL basic_w5 got=%h exp=%h", got_q[5], {1'b0, 1'b1, 32'h16171813}); end
    endtask

    task automatic test_full_frame();
        int users;
        users = 0;
        apply_reset();
        for (int i = 0; i < 20; i++) send_pixel(pix_of(i));
        wait_words(15);
        check_stream("frame", 15);
        for (int i = 0; i < 12 && i < got_q.size(); i++) users += int'(got_q[i][33]);
        checks++; if (users !== 1) begin failures++; $display("FAIL frame_tuser_count got=%0d exp=1", users); end
        checks++; if (got_q[5][32] !== 1'b1) begin failures++; $display("FAIL frame_tlast_w6 got=%b exp=1", got_q[5][32]); end
        checks++; if (got_q[11][32] !== 1'b1) begin failures++; $display("FAIL frame_tlast_w12 got=%b exp=1", got_q[11][32]); end
        checks++; if (got_q[12][33] !== 1'b1) begin failures++; $display("FAIL frame2_tuser got=%b exp=1", got_q[12][33]); end
        checks++; if (fd_cnt !== 1) begin failures++; $display("FAIL frame_done_count got=%0d exp=1", fd_cnt); end
        checks++; if (fd_words !== 12) begin failures++; $display("FAIL frame_done_after got=%0d exp=12", fd_words); end
        checks++; if (fd_lag !== 0) begin failures++; $display("FAIL frame_done_lag got=%0d exp=0", fd_lag); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int b;
        apply_reset();
        fork
            begin
                for (int i = 0; i < 16; i++) send_pixel(pix_of(i));
                bus.in_valid = 1'b0;
            end
            begin
                b = 0;
                while (!(got_q.size() >= 2 && bus.out_stream_tvalid) && b < 200) begin
                    @(posedge clk); #1;
                    b++;
                end
                checks++;
                if (bus.out_stream_tvalid !== 1'b1) begin failures++; $display("FAIL bp_start tvalid=%b required=1", bus.out_stream_tvalid); end
                held = bus.out_stream_tdata;
                bus.out_stream_tready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checks++; if (bus.out_stream_tvalid !== 1'b1) begin failures++; $display("FAIL bp_tvalid got=%b exp=1", bus.out_stream_tvalid); end
                    checks++; if (bus.out_stream_tdata !== held) begin failures++; $display("FAIL bp_tdata got=%h exp=%h", bus.out_stream_tdata, held); end
                    checks++; if (bus.in_stream_ready !== (model_phase == 0)) begin failures++; $display("FAIL bp_ready got=%b exp=%b", bus.in_stream_ready, model_phase == 0); end
                end
                @(posedge clk); #1;
                bus.out_stream_tready = 1'b1;
            end
        join
        wait_words(12);
        check_stream("bp", 12);
        checks++; if (fd_cnt !== 1) begin failures++; $display("FAIL bp_frame_done got=%0d exp=1", fd_cnt); end
    endtask

    task automatic test_throughput();
        apply_reset();
        fork
            begin
                for (int i = 0; i < 16; i++) send_pixel(pix_of(i + 100));
                bus.in_valid = 1'b0;
            end
            begin
                for (int j = 0; j <= 16; j++) begin
                    @(negedge clk);
                    if (j < 16) begin
                        checks++;
                        if (bus.in_stream_ready !== 1'b1) begin failures++; $display("FAIL tp_ready cycle=%0d got=0 exp=1", j); end
                    end
                    if (j >= 1) begin
                        checks++;
                        if (bus.out_stream_tvalid !== ((j % 4) != 1)) begin failures++; $display("FAIL tp_tvalid cycle=%0d got=%b exp=%b", j, bus.out_stream_tvalid, (j % 4) != 1); end
                    end
                end
            end
        join
        wait_words(12);
        check_stream("tp", 12);
    endtask

    task automatic test_reset_mid_frame();
        logic [23:0] px[6] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C,
                               24'h0D0E0F, 24'h101112};
        apply_reset();
        for (int i = 0; i < 6; i++) send_pixel(px[i]);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_stream_tvalid !== 1'b1) begin failures++; $display("FAIL mid_pre_tvalid got=%b exp=1", bus.out_stream_tvalid); end
        aresetn = 1'b0;
        #1;
        checks++; if (bus.out_stream_tvalid !== 1'b0) begin failures++; $display("FAIL mid_tvalid got=%b exp=0", bus.out_stream_tvalid); end
        checks++; if (bus.out_stream_tdata !== 32'h0) begin failures++; $display("FAIL mid_tdata got=%h exp=0", bus.out_stream_tdata); end
        checks++; if (bus.in_stream_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", bus.in_stream_ready); end
        checks++; if (dbg_phase !== 2'd0) begin failures++; $display("FAIL mid_phase got=%0d exp=0", dbg_phase); end
        model_clear();
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_pixel(px[i]);
        wait_words(3);
        checks++; if (got_q.size() !== 3) begin failures++; $display("FAIL mid_count got=%0d exp=3", got_q.size()); end
        checks++; if (got_q[0] !== {1'b1, 1'b0, 32'h06010203}) begin failures++; $display("FAIL mid_w0 got=%h exp=%h", got_q[0], {1'b1, 1'b0, 32'h06010203}); end
        checks++; if (got_q[1] !== {1'b0, 1'b0, 32'h08090405}) begin failures++; $display("FAIL mid_w1 got=%h exp=%h", got_q[1], {1'b0, 1'b0, 32'h08090405}); end
        checks++; if (got_q[2] !== {1'b0, 1'b0, 32'h0A0B0C07}) begin failures++; $display("FAIL mid_w2 got=%h exp=%h", got_q[2], {1'b0, 1'b0, 32'h0A0B0C07}); end
    endtask

    task automatic test_sparse();
        bit done;
        done = 1'b0;
        apply_reset();
        fork
            begin
                for (int i = 0; i < 32; i++) begin
                    bus.in_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send_pixel(pix_of(i + 40));
                end
                bus.in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.out_stream_tready = ($urandom_range(0, 3) != 0);
                end
                bus.out_stream_tready = 1'b1;
            end
        join
        wait_words(24);
        check_stream("sparse", 24);
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (got_q[i][32] !== ((i % 6) == 5)) begin failures++; $display("FAIL sparse_tlast%0d got=%b exp=%b", i, got_q[i][32], (i % 6) == 5); end
        end
        checks++; if (fd_cnt !== 2) begin failures++; $display("FAIL sparse_frame_done got=%0d exp=2", fd_cnt); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_pack();
        test_full_frame();
        test_backpressure();
        test_throughput();
        test_reset_mid_frame();
        test_sparse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
